spike_vote_classifier: RTL and testbench

SPIKE_VOTE_CLASSIFIER -- requirements
Module: spike_vote_classifier

---
 rtl/spike_vote_classifier_if.sv | 32 +++
 rtl/spike_vote_classifier.sv | 164 ++++++++++++++++
 tb/tb_spike_vote_classifier.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spike_vote_classifier_if.sv
// Handshake and data bundle for spike_vote_classifier.
//   master : drives start, step_valid, spike, result_ready; observes the result
//   slave  : the classifier side (inverse directions)
//   start/step_valid/spike   : window control and per-timestep spike vector
//   busy                     : accumulation or argmax scan in progress
//   result_valid/ready       : result handshake
//   result_class/count       : winning class index and its spike count
//   no_spike                 : every class count was zero
interface spike_vote_classifier_if #(
    parameter int NUM_CLASSES = 10,
    parameter int CNT_WIDTH   = 9
) ();
    logic                           start;
    logic                           step_valid;
    logic [NUM_CLASSES-1:0]         spike;
    logic                           busy;
    logic                           result_valid;
    logic                           result_ready;
    logic [$clog2(NUM_CLASSES)-1:0] result_class;
    logic [CNT_WIDTH-1:0]           result_count;
    logic                           no_spike;

    modport master (
        output start, step_valid, spike, result_ready,
        input  busy, result_valid, result_class, result_count, no_spike
    );

    modport slave (
        input  start, step_valid, spike, result_ready,
        output busy, result_valid, result_class, result_count, no_spike
    );
endinterface

// File: rtl/spike_vote_classifier.sv
// Spike-count voting classifier for the output layer of a spiking network.
// A window of WINDOW accepted timesteps is accumulated into one saturating
// counter per class, then the counters are scanned one per cycle to find the
// class with the most spikes (ties resolve to the lowest index).
//   clk    : sole clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : spike_vote_classifier_if.slave (control, spikes, result handshake)
module spike_vote_classifier #(
    parameter int NUM_CLASSES = 10,
    parameter int WINDOW      = 256,
    parameter int CNT_WIDTH   = 9
) (
    input  logic                     clk,
    input  logic                     rst_n,
    spike_vote_classifier_if.slave   bus
);
    localparam int IDX_W  = $clog2(NUM_CLASSES);
    localparam int STEP_W = $clog2(WINDOW + 1);
    localparam logic [STEP_W-1:0]    LAST_STEP = STEP_W'(WINDOW - 1);
    localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NUM_CLASSES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_ARGMAX = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [CNT_WIDTH-1:0]   cnt_r [NUM_CLASSES];
    logic [STEP_W-1:0]      step_cnt_r;
    logic [IDX_W-1:0]       scan_idx_r;
    logic [IDX_W-1:0]       best_idx_r;
    logic [CNT_WIDTH-1:0]   best_cnt_r;
    logic                   no_spike_r;
    logic                   busy_r;
    logic                   result_valid_r;
    logic [CNT_WIDTH-1:0]   cand_cnt_s;
    logic                   take_s;

    // Saturating increment: a full counter holds its value instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_WIDTH'(1);
        end
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (bus.start) state_s = S_ACCUM;
                else           state_s = S_IDLE;
            end
            S_ACCUM: begin
                if (bus.step_valid && (step_cnt_r == LAST_STEP)) state_s = S_ARGMAX;
                else                                             state_s = S_ACCUM;
            end
            S_ARGMAX: begin
                if (scan_idx_r == LAST_IDX) state_s = S_DONE;
                else                        state_s = S_ARGMAX;
            end
            S_DONE: begin
                // start here is deliberately not looked at: the FSM leaves
                // DONE on this edge and only IDLE accepts a new window.
                if (bus.result_ready) state_s = S_IDLE;
                else                  state_s = S_DONE;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Candidate for the argmax scan; strict compare keeps the lowest index on ties.
    always_comb begin
        cand_cnt_s = cnt_r[scan_idx_r];
        take_s     = 1'b0;
        if (state_r == S_ARGMAX) begin
            take_s = (cand_cnt_s > best_cnt_r);
        end else begin
            take_s = 1'b0;
        end
    end

    // Counters, scan pointer and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CLASSES; i++) cnt_r[i] <= '0;
            step_cnt_r <= '0;
            scan_idx_r <= '0;
            best_idx_r <= '0;
            best_cnt_r <= '0;
            no_spike_r <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.start) begin
                        for (int i = 0; i < NUM_CLASSES; i++) cnt_r[i] <= '0;
                        step_cnt_r <= '0;
                        scan_idx_r <= '0;
                        best_idx_r <= '0;
                        best_cnt_r <= '0;
                        no_spike_r <= 1'b0;
                    end
                end
                S_ACCUM: begin
                    if (bus.step_valid) begin
                        for (int i = 0; i < NUM_CLASSES; i++) begin
                            if (bus.spike[i]) cnt_r[i] <= sat_inc(cnt_r[i]);
                        end
                        step_cnt_r <= step_cnt_r + STEP_W'(1);
                    end
                end
                S_ARGMAX: begin
                    if (take_s) begin
                        best_idx_r <= scan_idx_r;
                        best_cnt_r <= cand_cnt_s;
                    end
                    scan_idx_r <= scan_idx_r + IDX_W'(1);
                    // Winner is zero only if nothing beat the cleared best of 0.
                    if (scan_idx_r == LAST_IDX) begin
                        no_spike_r <= (best_cnt_r == CNT_WIDTH'(0)) && !take_s;
                    end
                end
                S_DONE: begin
                    // Result registers hold while presented.
                end
                default: begin
                    step_cnt_r <= '0;
                end
            endcase
        end
    end

    // Status flags registered from the next state so they align with state_r.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r         <= 1'b0;
            result_valid_r <= 1'b0;
        end else begin
            busy_r         <= (state_s == S_ACCUM) || (state_s == S_ARGMAX);
            result_valid_r <= (state_s == S_DONE);
        end
    end

    assign bus.busy         = busy_r;
    assign bus.result_valid = result_valid_r;
    assign bus.result_class = best_idx_r;
    assign bus.result_count = best_cnt_r;
    assign bus.no_spike     = no_spike_r;
endmodule

// File: tb/tb_spike_vote_classifier.sv
// Directed bench for spike_vote_classifier with a queue-based scoreboard.
// Two instances: default parameters, and WINDOW=600 for the saturation case.
module tb_spike_vote_classifier;
    logic clk;
    logic rst_n;

    typedef struct {
        int cls;
        int cnt;
        int ns;
    } exp_t;

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    int   n_vec;
    int   n_err;

    spike_vote_classifier_if #(.NUM_CLASSES(10), .CNT_WIDTH(9)) ifa ();
    spike_vote_classifier_if #(.NUM_CLASSES(10), .CNT_WIDTH(9)) ifb ();

    spike_vote_classifier #(.NUM_CLASSES(10), .WINDOW(256), .CNT_WIDTH(9)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    spike_vote_classifier #(.NUM_CLASSES(10), .WINDOW(600), .CNT_WIDTH(9)) dut_w (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic st, input logic sv,
                         input logic [9:0] sp, input logic rr);
        if (sel == 0) begin
            ifa.start = st; ifa.step_valid = sv; ifa.spike = sp; ifa.result_ready = rr;
        end else begin
            ifb.start = st; ifb.step_valid = sv; ifb.spike = sp; ifb.result_ready = rr;
        end
    endtask

    function automatic logic get_valid(input int sel);
        return (sel == 0) ? ifa.result_valid : ifb.result_valid;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? ifa.busy : ifb.busy;
    endfunction

    function automatic logic [9:0] spike_pat(input int tid, input int s);
        logic [9:0] p;
        p = 10'd0;
        case (tid)
            1: p[3] = 1'b1;
            2: begin
                p[2] = (s < 100);
                p[7] = (s >= 100) && (s < 200);
                p[0] = (s < 99);
                p[9] = (s >= 200);
            end
            4: begin
                if (s % 3 == 0) p[1] = 1'b1;
                else            p[4] = 1'b1;
            end
            5: begin
                p[9] = 1'b1;
                p[8] = (s % 2 == 0);
                p[0] = (s < 255);
            end
            6: begin
                p[1] = 1'b1;
                p[6] = (s < 50);
            end
            7: begin
                p[5] = 1'b1;
                p[2] = (s < 400);
            end
            8: p[6] = 1'b1;
            default: p = 10'd0;
        endcase
        return p;
    endfunction

    task automatic push_exp(input int sel, input int cls, input int cnt, input int ns);
        exp_t e;
        e.cls = cls; e.cnt = cnt; e.ns = ns;
        if (sel == 0) exp_q0.push_back(e);
        else          exp_q1.push_back(e);
    endtask

    task automatic check_reset_outputs(input int sel, input string tag);
        if (sel == 0) begin
            check({tag, "_busy"},  int'(ifa.busy), 0);
            check({tag, "_valid"}, int'(ifa.result_valid), 0);
            check({tag, "_class"}, int'(ifa.result_class), 0);
            check({tag, "_count"}, int'(ifa.result_count), 0);
            check({tag, "_nospk"}, int'(ifa.no_spike), 0);
        end else begin
            check({tag, "_busy"},  int'(ifb.busy), 0);
            check({tag, "_valid"}, int'(ifb.result_valid), 0);
            check({tag, "_class"}, int'(ifb.result_class), 0);
            check({tag, "_count"}, int'(ifb.result_count), 0);
            check({tag, "_nospk"}, int'(ifb.no_spike), 0);
        end
    endtask

    // One full classification: start, steps, latency, hold, handshake with start.
    task automatic run_window(input int sel, input int tid, input int nsteps,
                              input bit toggle, input int mid_start, input int hold);
        int lat;
        @(posedge clk); #1; drive(sel, 1'b1, 1'b0, 10'd0, 1'b0);
        @(posedge clk); #1; drive(sel, 1'b0, 1'b0, 10'd0, 1'b0);
        check($sformatf("t%0d_busy_accum", tid), int'(get_busy(sel)), 1);
        for (int s = 0; s < nsteps; s++) begin
            drive(sel, (s == mid_start), 1'b1, spike_pat(tid, s), 1'b0);
            if (s != nsteps - 1) begin
                @(posedge clk); #1;
                if (toggle) begin
                    drive(sel, 1'b0, 1'b0, 10'h3FF, 1'b0);
                    @(posedge clk); #1;
                end
            end
        end
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'b0, 10'd0, 1'b0);
        lat = 0;
        while (!get_valid(sel) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("t%0d_latency", tid), lat, 10);
        repeat (hold) begin
            @(posedge clk); #1;
        end
        check($sformatf("t%0d_valid_held", tid), int'(get_valid(sel)), 1);
        // Accept the result with start asserted in the same cycle.
        drive(sel, 1'b1, 1'b0, 10'd0, 1'b1);
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'b0, 10'd0, 1'b0);
        check($sformatf("t%0d_valid_drop", tid), int'(get_valid(sel)), 0);
        check($sformatf("t%0d_idle_busy", tid), int'(get_busy(sel)), 0);
        @(posedge clk); #1;
        check($sformatf("t%0d_start_ignored", tid), int'(get_busy(sel)), 0);
    endtask

    // Scoreboard monitor for the default instance.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ifa.result_valid) begin
                n_vec++;
                if (exp_q0.size() == 0) begin
                    n_err++;
                    $display("FAIL dut_unexpected_result: got class %0d count %0d", ifa.result_class, ifa.result_count);
                end else begin
                    e = exp_q0[0];
                    if (int'(ifa.result_class) != e.cls || int'(ifa.result_count) != e.cnt ||
                        int'(ifa.no_spike) != e.ns) begin
                        n_err++;
                        $display("FAIL dut_result: got class %0d count %0d no_spike %0d expected class %0d count %0d no_spike %0d",
                                 ifa.result_class, ifa.result_count, ifa.no_spike, e.cls, e.cnt, e.ns);
                    end
                    if (ifa.result_ready) void'(exp_q0.pop_front());
                end
            end
        end
    end

    // Scoreboard monitor for the WINDOW=600 instance.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ifb.result_valid) begin
                n_vec++;
                if (exp_q1.size() == 0) begin
                    n_err++;
                    $display("FAIL dutw_unexpected_result: got class %0d count %0d", ifb.result_class, ifb.result_count);
                end else begin
                    e = exp_q1[0];
                    if (int'(ifb.result_class) != e.cls || int'(ifb.result_count) != e.cnt ||
                        int'(ifb.no_spike) != e.ns) begin
                        n_err++;
                        $display("FAIL dutw_result: got class %0d count %0d no_spike %0d expected class %0d count %0d no_spike %0d",
                                 ifb.result_class, ifb.result_count, ifb.no_spike, e.cls, e.cnt, e.ns);
                    end
                    if (ifb.result_ready) void'(exp_q1.pop_front());
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 10'd0, 1'b0);
        drive(1, 1'b0, 1'b0, 10'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs(0, "rst_a");
        check_reset_outputs(1, "rst_b");
        rst_n = 1'b1;

        // Single class spikes every step.
        push_exp(0, 3, 256, 0);
        run_window(0, 1, 256, 1'b0, -1, 0);

        // Tie between classes 2 and 7 at 100 spikes.
        push_exp(0, 2, 100, 0);
        run_window(0, 2, 256, 1'b0, -1, 1);

        // Silent window.
        push_exp(0, 0, 0, 1);
        run_window(0, 3, 256, 1'b0, -1, 0);

        // step_valid toggling, garbage spikes on idle cycles, stray start, held result.
        push_exp(0, 4, 170, 0);
        run_window(0, 4, 256, 1'b1, 50, 5);

        // Winner at the last index.
        push_exp(0, 9, 256, 0);
        run_window(0, 5, 256, 1'b0, -1, 2);

        // Reset in the middle of accumulation.
        @(posedge clk); #1; drive(0, 1'b1, 1'b0, 10'd0, 1'b0);
        @(posedge clk); #1; drive(0, 1'b0, 1'b0, 10'd0, 1'b0);
        for (int s = 0; s < 100; s++) begin
            drive(0, 1'b0, 1'b1, spike_pat(8, s), 1'b0);
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        drive(0, 1'b1, 1'b1, 10'h3FF, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(0, 1'b0, 1'b0, 10'd0, 1'b0);
        check_reset_outputs(0, "midrst");
        @(posedge clk); #1;
        check("midrst_stay_idle", int'(ifa.busy), 0);
        push_exp(0, 1, 256, 0);
        run_window(0, 6, 256, 1'b0, -1, 0);

        // Saturation with a 600-step window.
        push_exp(1, 5, 511, 0);
        run_window(1, 7, 600, 1'b0, -1, 0);

        repeat (3) @(posedge clk);
        #1;
        check("queue0_drained", exp_q0.size(), 0);
        check("queue1_drained", exp_q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
